// File: rtl/sm_rom_accumulator.sv
// sm_rom_accumulator: sums COUNT sign-magnitude ROM words from BASE with sticky overflow
module sm_rom_accumulator #(
  parameter int N = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [N-1:0]      rom_data,
  output logic [N-1:0]      add_a,
  output logic [N-1:0]      add_b,
  input  logic [N-1:0]      add_sum,
  output logic [N-1:0]      result,
  output logic              overflow,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, FETCH, ACC, DONE} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] base, cnt, idx, idx_inc;
  logic [N-1:0] b_norm, sum_norm, mag_sum;
  logic ovf;
  // operand shaping, overflow detection and Moore next-state
  always_comb begin
    b_norm = ~|rom_data[N-2:0] ? '0 : rom_data;
    sum_norm = ~|add_sum[N-2:0] ? '0 : add_sum;
    mag_sum = {1'b0, result[N-2:0]} + {1'b0, b_norm[N-2:0]};
    ovf = (result[N-1] == b_norm[N-1]) && mag_sum[N-1];
    idx_inc = idx + ADDR_W'(1);
    add_a = result;
    add_b = b_norm;
    busy = (state == FETCH) || (state == ACC);
    done = state == DONE;
    state_nxt = state == IDLE  ? (!start ? IDLE : ~|count ? DONE : FETCH)
              : state == FETCH ? ACC
              : state == ACC   ? (idx_inc == cnt ? DONE : FETCH)
              : IDLE;
  end
  // state, run context and accumulator; the ROM address is presented on entry to FETCH
  // so that the synchronous ROM returns the word during ACC
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      rom_addr <= '0;
      result <= '0;
      overflow <= 1'b0;
      base <= '0;
      cnt <= '0;
      idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        base <= base_addr;
        cnt <= count;
        idx <= '0;
        result <= '0;
        overflow <= 1'b0;
        if (|count) rom_addr <= base_addr;
      end
      if (state == ACC) begin
        result <= sum_norm;
        idx <= idx_inc;
        overflow <= overflow | ovf;
        if (idx_inc != cnt) rom_addr <= base + idx_inc;
      end
    end
  end
endmodule

// File: tb/tb_sm_rom_accumulator.sv
// tb_sm_rom_accumulator: scoreboard bench with ROM and sign-magnitude adder models
module tb_sm_rom_accumulator;
  typedef struct {logic [3:0] r; logic o; int lat; int s;} exp_t;
  logic clk = 0, reset_n = 0, start = 0, overflow, busy, done;
  logic [7:0] base_addr = 0, count = 0, rom_addr;
  logic [3:0] rom_data, add_a, add_b, add_sum, result;
  logic [3:0] rom [0:255];
  exp_t exp_q[$];
  logic [7:0] addr_q[$];
  exp_t e;
  int vectors = 0, fails = 0, cyc = 0;
  bit ph = 0, prev_done = 0;

  sm_rom_accumulator dut (.clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .count(count), .rom_addr(rom_addr), .rom_data(rom_data), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .result(result), .overflow(overflow), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [3:0] smadd(input logic [3:0] a, input logic [3:0] b);
    logic [2:0] ma, mb;
    ma = a[2:0];
    mb = b[2:0];
    if (a[3] == b[3]) return {a[3], 3'(ma + mb)};
    if (ma > mb) return {a[3], 3'(ma - mb)};
    return {b[3], 3'(mb - ma)};
  endfunction
  always_comb add_sum = smadd(add_a, add_b);

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("result", int'(result), int'(e.r));
        chk("overflow", int'(overflow), int'(e.o));
        chk("done_latency", cyc - e.s, e.lat);
        chk("done_single_cycle", int'(prev_done), 0);
      end
    end
    if (busy) begin
      if (!ph) begin
        if (addr_q.size() == 0) chk("extra_fetch", 1, 0);
        else chk("rom_addr", int'(rom_addr), int'(addr_q.pop_front()));
      end
      ph = ~ph;
    end else ph = 0;
    prev_done = done;
  end

  task automatic run(input logic [7:0] b, input logic [7:0] c, input logic [3:0] er,
                     input logic eo, input bit poke);
    int t;
    for (int i = 0; i < int'(c); i++) addr_q.push_back(8'(b + 8'(i)));
    start = 1;
    base_addr = b;
    count = c;
    @(posedge clk); #1;
    start = 0;
    exp_q.push_back('{er, eo, 2 * int'(c), cyc});
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
      if (poke && t == 1) begin start = 1; base_addr = 8'h55; count = 8'd9; end
      if (poke && t == 2) start = 0;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
    @(posedge clk); #1;
    chk("addr_all_seen", addr_q.size(), 0);
    addr_q.delete();
  endtask

  initial begin
    logic [7:0] saved;
    for (int i = 0; i < 256; i++) rom[i] = 4'b0000;
    rom[10] = 4'b0011; rom[11] = 4'b0010; rom[12] = 4'b1001;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_busy", int'(busy), 0);
    reset_n = 1;
    // aborted run: reset asserted mid-run must yield no done pulse
    for (int i = 0; i < 3; i++) addr_q.push_back(8'(10 + i));
    start = 1; base_addr = 10; count = 3;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    addr_q.delete();
    chk("abort_rom_addr", int'(rom_addr), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_overflow", int'(overflow), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    reset_n = 1;
    repeat (10) @(posedge clk);
    #1;
    run(8'd10, 8'd3, 4'b0100, 1'b0, 0);
    rom[0] = 4'b0011; rom[1] = 4'b1011;
    run(8'd0, 8'd2, 4'b0000, 1'b0, 0);
    rom[0] = 4'b0101; rom[1] = 4'b0100; rom[2] = 4'b0001;
    run(8'd0, 8'd2, 4'b0001, 1'b1, 0);
    run(8'd2, 8'd1, 4'b0001, 1'b0, 0);
    rom[3] = 4'b1000; rom[4] = 4'b1010;
    run(8'd3, 8'd2, 4'b1010, 1'b0, 0);
    rom[5] = 4'b1110; rom[6] = 4'b1011;
    run(8'd5, 8'd2, 4'b1001, 1'b1, 0);
    saved = rom_addr;
    run(8'd77, 8'd0, 4'b0000, 1'b0, 0);
    chk("count0_rom_addr", int'(rom_addr), int'(saved));
    rom[255] = 4'b0010; rom[0] = 4'b0011;
    run(8'd255, 8'd2, 4'b0101, 1'b0, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_after_poke", int'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
